// File: rtl/pll_phase_ctrl_if.sv
// ----------------------------------------------------------------------------
// pll_phase_ctrl_if
// Phase-shift request bus between a requester and pll_phase_ctrl.
//
// Signals:
//   req_valid  requester -> controller  request valid
//   req_sel    requester -> controller  PLL output to shift (PHASESEL code)
//   req_dir    requester -> controller  shift direction (PHASEDIR)
//   req_count  requester -> controller  number of phase steps
//   req_ready  controller -> requester  request accepted this cycle
//   busy       controller -> requester  phase-step sequence in progress
//
// Modports: master (requester side), slave (controller side).
// ----------------------------------------------------------------------------
interface pll_phase_ctrl_if #(
   parameter int STEPS_W = 8
);
   logic               req_valid;
   logic [1:0]         req_sel;
   logic               req_dir;
   logic [STEPS_W-1:0] req_count;
   logic               req_ready;
   logic               busy;

   modport master (
      output req_valid, req_sel, req_dir, req_count,
      input  req_ready, busy
   );

   modport slave (
      input  req_valid, req_sel, req_dir, req_count,
      output req_ready, busy
   );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ----------------------------------------------------------------------------
// pll_phase_ctrl
// Power-up / relock sequencer and dynamic phase-shift driver for an ECP5
// EHXPLLL. Pulses the PLL reset, qualifies LOCK, holds the system in reset
// until lock has been continuously present for LOCK_STABLE cycles, and
// recovers on lock loss or lock timeout. While running, accepts phase-shift
// requests and generates PHASESEL/PHASEDIR/PHASESTEP sequences.
// Clocked from the PLL reference so output glitches during steps are harmless.
//
// Ports:
//   clock         in   25 MHz reference clock
//   reset_n       in   asynchronous active-low reset
//   pll_locked    in   PLL LOCK, asynchronous to clock
//   pll_rst       out  PLL RST, active high
//   phasesel      out  PLL PHASESEL[1:0]
//   phasedir      out  PLL PHASEDIR
//   phasestep     out  PLL PHASESTEP, idle high, active-low pulses
//   sys_rst_n     out  system reset, released synchronously once running
//   relock_count  out  lock-loss events while running, saturating at 255
//   req_bus       slave side of the phase-shift request bus
// ----------------------------------------------------------------------------
module pll_phase_ctrl #(
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int RST_CYCLES   = 16,
   parameter int STEP_WIDTH   = 4,
   parameter int STEP_GAP     = 8,
   parameter int STEPS_W      = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                pll_locked,
   output logic                pll_rst,
   output logic [1:0]          phasesel,
   output logic                phasedir,
   output logic                phasestep,
   output logic                sys_rst_n,
   output logic [7:0]          relock_count,
   pll_phase_ctrl_if.slave     req_bus
);

   // One shared counter serves every timed state, so size it for the longest.
   localparam int MAX_AB = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
   localparam int MAX_CD = (STEP_WIDTH > STEP_GAP) ? STEP_WIDTH : STEP_GAP;
   localparam int MAX_EF = (MAX_CD > RST_CYCLES) ? MAX_CD : RST_CYCLES;
   localparam int MAX_P  = (MAX_AB > MAX_EF) ? MAX_AB : MAX_EF;
   localparam int CNT_W  = $clog2(MAX_P + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] WIDTH_LAST   = CNT_W'(STEP_WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STEP_GAP - 1);

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      SETUP,
      STEP,
      GAP
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [STEPS_W-1:0] remaining_reg, remaining_next;
   logic               pll_rst_reg, pll_rst_next;
   logic [1:0]         phasesel_reg, phasesel_next;
   logic               phasedir_reg, phasedir_next;
   logic               phasestep_reg, phasestep_next;
   logic               busy_reg, busy_next;
   logic               sys_rst_n_reg, sys_rst_n_next;
   logic [7:0]         relock_count_reg, relock_count_next;
   logic [1:0]         lock_sync_reg;
   logic               lock_s;
   logic               handshake;

   // Two-flop synchronizer; nothing downstream ever looks at raw pll_locked.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_sync_reg <= 2'b00;
      end else begin
         lock_sync_reg <= {lock_sync_reg[0], pll_locked};
      end
   end

   assign lock_s    = lock_sync_reg[1];
   assign req_bus.req_ready = (state_reg == RUN) && lock_s;
   assign handshake = req_bus.req_valid && req_bus.req_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= RESET_PLL;
         cnt_reg          <= '0;
         remaining_reg    <= '0;
         pll_rst_reg      <= 1'b1;
         phasesel_reg     <= 2'b00;
         phasedir_reg     <= 1'b0;
         phasestep_reg    <= 1'b1;
         busy_reg         <= 1'b0;
         sys_rst_n_reg    <= 1'b0;
         relock_count_reg <= 8'd0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         remaining_reg    <= remaining_next;
         pll_rst_reg      <= pll_rst_next;
         phasesel_reg     <= phasesel_next;
         phasedir_reg     <= phasedir_next;
         phasestep_reg    <= phasestep_next;
         busy_reg         <= busy_next;
         sys_rst_n_reg    <= sys_rst_n_next;
         relock_count_reg <= relock_count_next;
      end
   end

   // Outputs are computed one cycle ahead so every PLL-facing pin is a flop.
   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      remaining_next    = remaining_reg;
      pll_rst_next      = pll_rst_reg;
      phasesel_next     = phasesel_reg;
      phasedir_next     = phasedir_reg;
      phasestep_next    = phasestep_reg;
      busy_next         = busy_reg;
      sys_rst_n_next    = sys_rst_n_reg;
      relock_count_next = relock_count_reg;

      case (state_reg)
         RESET_PLL: begin
            if (cnt_reg == RST_LAST) begin
               state_next   = WAIT_LOCK;
               cnt_next     = '0;
               pll_rst_next = 1'b0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               state_next   = RESET_PLL;
               cnt_next     = '0;
               pll_rst_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == STABLE_LAST) begin
               state_next     = RUN;
               cnt_next       = '0;
               sys_rst_n_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RUN: begin
            // A zero-step request is simply acknowledged; outputs stay put.
            if (handshake && (req_bus.req_count != '0)) begin
               state_next     = SETUP;
               cnt_next       = '0;
               phasesel_next  = req_bus.req_sel;
               phasedir_next  = req_bus.req_dir;
               remaining_next = req_bus.req_count;
               busy_next      = 1'b1;
            end
         end
         SETUP: begin
            state_next     = STEP;
            cnt_next       = '0;
            phasestep_next = 1'b0;
         end
         STEP: begin
            if (cnt_reg == WIDTH_LAST) begin
               state_next     = GAP;
               cnt_next       = '0;
               phasestep_next = 1'b1;
               remaining_next = remaining_reg - STEPS_W'(1);
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               cnt_next = '0;
               if (remaining_reg == '0) begin
                  state_next = RUN;
                  busy_next  = 1'b0;
               end else begin
                  state_next     = STEP;
                  phasestep_next = 1'b0;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next   = RESET_PLL;
            cnt_next     = '0;
            pll_rst_next = 1'b1;
         end
      endcase

      // Lock loss while running overrides whatever the case above decided:
      // abandon the request, park PHASESTEP high and drop the system reset.
      if (!lock_s && ((state_reg == RUN) || (state_reg == SETUP) ||
                      (state_reg == STEP) || (state_reg == GAP))) begin
         state_next     = WAIT_LOCK;
         cnt_next       = '0;
         remaining_next = '0;
         phasestep_next = 1'b1;
         busy_next      = 1'b0;
         sys_rst_n_next = 1'b0;
         if (relock_count_reg != 8'hFF) begin
            relock_count_next = relock_count_reg + 8'd1;
         end
      end
   end

   assign pll_rst      = pll_rst_reg;
   assign phasesel     = phasesel_reg;
   assign phasedir     = phasedir_reg;
   assign phasestep    = phasestep_reg;
   assign sys_rst_n    = sys_rst_n_reg;
   assign relock_count = relock_count_reg;
   assign req_bus.busy = busy_reg;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pll_phase_ctrl
// Directed bench for pll_phase_ctrl with short timing parameters
// (LOCK_STABLE=8, LOCK_TIMEOUT=32, RST_CYCLES=4, STEP_WIDTH=2, STEP_GAP=3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_pll_phase_ctrl;

   logic       clock;
   logic       reset_n;
   logic       pll_locked;
   logic       pll_rst;
   logic [1:0] phasesel;
   logic       phasedir;
   logic       phasestep;
   logic       sys_rst_n;
   logic [7:0] relock_count;

   int n_total = 0;
   int n_bad   = 0;

   pll_phase_ctrl_if #(.STEPS_W(8)) req_bus ();

   pll_phase_ctrl #(
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (32),
      .RST_CYCLES   (4),
      .STEP_WIDTH   (2),
      .STEP_GAP     (3),
      .STEPS_W      (8)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .sys_rst_n    (sys_rst_n),
      .relock_count (relock_count),
      .req_bus      (req_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Counts rising edges until sys_rst_n is seen high (n=101 on timeout).
   // Optionally glitches pll_locked low for one cycle after edge glitch_at.
   task automatic wait_sys_up(input int glitch_at, output int n);
      n = 101;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (sys_rst_n) begin
            n = k;
            break;
         end
         if (k == glitch_at)     pll_locked = 1'b0;
         if (k == glitch_at + 1) pll_locked = 1'b1;
      end
   endtask

   // Optionally issues one request, then records 20 cycles of outputs.
   // Bit i of each vector is sampled after the i-th edge (edge 0 = handshake).
   task automatic trace(input logic issue, input logic [1:0] sel, input logic dir,
                        input logic [7:0] cnt, input int drop_at,
                        output logic [19:0] ps_v, output logic [19:0] busy_v,
                        output logic [19:0] rdy_v, output logic [19:0] sys_v,
                        output logic [1:0] sel0, output logic dir0);
      ps_v = '0; busy_v = '0; rdy_v = '0; sys_v = '0; sel0 = '0; dir0 = 1'b0;
      if (issue) begin
         req_bus.req_valid = 1'b1;
         req_bus.req_sel   = sel;
         req_bus.req_dir   = dir;
         req_bus.req_count = cnt;
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         @(negedge clock);
         req_bus.req_valid = 1'b0;
         ps_v[i]   = phasestep;
         busy_v[i] = req_bus.busy;
         rdy_v[i]  = req_bus.req_ready;
         sys_v[i]  = sys_rst_n;
         if (i == 0) begin
            sel0 = phasesel;
            dir0 = phasedir;
         end
         if (i == drop_at) pll_locked = 1'b0;
      end
      $display("txn issue=%0d sel=%0d dir=%0d count=%0d ps=%h busy=%h rdy=%h sys=%h",
               issue, sel, dir, cnt, ps_v, busy_v, rdy_v, sys_v);
   endtask

   initial begin
      logic [19:0] ps_v, busy_v, rdy_v, sys_v;
      logic [1:0]  sel0;
      logic        dir0;
      int          n;
      int          hi_cnt, sys_hi, first_rise;
      logic        prev;

      reset_n           = 1'b0;
      pll_locked        = 1'b0;
      req_bus.req_valid = 1'b0;
      req_bus.req_sel   = 2'd0;
      req_bus.req_dir   = 1'b0;
      req_bus.req_count = 8'd0;

      // Reset values
      @(negedge clock);
      @(negedge clock);
      chk("rst_pll_rst",   pll_rst, 1);
      chk("rst_phasestep", phasestep, 1);
      chk("rst_phasesel",  phasesel, 0);
      chk("rst_phasedir",  phasedir, 0);
      chk("rst_busy",      req_bus.busy, 0);
      chk("rst_sys",       sys_rst_n, 0);
      chk("rst_relock",    relock_count, 0);
      chk("rst_ready",     req_bus.req_ready, 0);

      // Lock never arrives: 4-cycle PLL reset pulses every 36 cycles.
      reset_n    = 1'b1;
      prev       = pll_rst;
      hi_cnt     = 0;
      sys_hi     = 0;
      first_rise = 0;
      for (int k = 1; k <= 72; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (pll_rst && !prev && first_rise == 0) first_rise = k;
         hi_cnt += int'(pll_rst);
         sys_hi += int'(sys_rst_n);
         prev = pll_rst;
      end
      $display("txn nolock rst_hi=%0d first_rise=%0d sys_hi=%0d", hi_cnt, first_rise, sys_hi);
      chk("nolock_rst_hi",     hi_cnt, 8);
      chk("nolock_first_rise", first_rise, 36);
      chk("nolock_sys_hi",     sys_hi, 0);

      // Fresh start: lock arrives 10 cycles after reset release.
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(posedge clock);
      @(negedge clock);
      pll_locked = 1'b1;
      wait_sys_up(-1, n);
      $display("txn lockup edges=%0d", n);
      chk("lockup_edges", n, 11);
      chk("lockup_ready", req_bus.req_ready, 1);
      chk("lockup_busy",  req_bus.busy, 0);

      // Three steps on output 2, direction 1.
      trace(1'b1, 2'd2, 1'b1, 8'd3, -1, ps_v, busy_v, rdy_v, sys_v, sel0, dir0);
      chk("step3_sel0",  sel0, 2);
      chk("step3_dir0",  dir0, 1);
      chk("step3_ps",    ps_v, 20'hFE739);
      chk("step3_busy",  busy_v, 20'h0FFFF);
      chk("step3_ready", rdy_v, 20'hF0000);
      chk("step3_sys",   sys_v, 20'hFFFFF);

      // Zero-step request: acknowledged, nothing moves.
      chk("zero_ready_pre", req_bus.req_ready, 1);
      trace(1'b1, 2'd1, 1'b0, 8'd0, -1, ps_v, busy_v, rdy_v, sys_v, sel0, dir0);
      chk("zero_ps",     ps_v, 20'hFFFFF);
      chk("zero_busy",   busy_v, 20'h00000);
      chk("zero_ready",  rdy_v, 20'hFFFFF);
      chk("zero_selhold", phasesel, 2);
      chk("zero_dirhold", phasedir, 1);

      // Lock drops during the second low pulse.
      trace(1'b1, 2'd1, 1'b0, 8'd3, 6, ps_v, busy_v, rdy_v, sys_v, sel0, dir0);
      chk("drop_sel0",   sel0, 1);
      chk("drop_ps",     ps_v, 20'hFFF39);
      chk("drop_busy",   busy_v, 20'h001FF);
      chk("drop_sys",    sys_v, 20'h001FF);
      chk("drop_ready",  rdy_v, 20'h00000);
      chk("drop_relock", relock_count, 1);

      pll_locked = 1'b1;
      wait_sys_up(-1, n);
      $display("txn relock edges=%0d", n);
      chk("relock_edges", n, 11);

      // The abandoned request must not resume.
      trace(1'b0, 2'd0, 1'b0, 8'd0, -1, ps_v, busy_v, rdy_v, sys_v, sel0, dir0);
      chk("idle_ps",     ps_v, 20'hFFFFF);
      chk("idle_busy",   busy_v, 20'h00000);
      chk("idle_sys",    sys_v, 20'hFFFFF);
      chk("idle_relock", relock_count, 1);

      // Asynchronous reset in the middle of a step pulse.
      req_bus.req_valid = 1'b1;
      req_bus.req_sel   = 2'd3;
      req_bus.req_dir   = 1'b1;
      req_bus.req_count = 8'd2;
      @(posedge clock);
      @(negedge clock);
      req_bus.req_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("async_ps_pre", phasestep, 0);
      #2 reset_n = 1'b0;
      #1;
      $display("txn async_reset ps=%0d pll_rst=%0d", phasestep, pll_rst);
      chk("async_ps",      phasestep, 1);
      chk("async_pll_rst", pll_rst, 1);
      chk("async_sys",     sys_rst_n, 0);
      chk("async_busy",    req_bus.busy, 0);
      chk("async_relock",  relock_count, 0);
      chk("async_sel",     phasesel, 0);
      @(negedge clock);
      pll_locked = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;

      // One-cycle lock glitch reaching the FSM at stable count 5.
      repeat (10) @(posedge clock);
      @(negedge clock);
      pll_locked = 1'b1;
      wait_sys_up(6, n);
      $display("txn glitch edges=%0d", n);
      chk("glitch_edges",  n, 18);
      chk("glitch_relock", relock_count, 0);
      chk("glitch_ready",  req_bus.req_ready, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Sequencer for the ECP5 EHXPLLL that generates the core and panel clocks.
- Resets the PLL, qualifies LOCK, and releases a synchronous system reset only after lock has been stable for a set time.
- Recovers automatically from lock loss or lock timeout.
- Once running, accepts dynamic phase-shift requests and drives PHASESEL/PHASEDIR/PHASESTEP for the panel clock.
- Runs on the 25 MHz PLL reference clock, so PLL output glitches during phase steps never affect it.

Parameters:
LOCK_STABLE, 1024, consecutive synchronized-lock cycles required before run
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before re-resetting the PLL
RST_CYCLES, 16, PLL reset pulse width in cycles
STEP_WIDTH, 4, cycles phasestep is held low per step
STEP_GAP, 8, cycles phasestep is held high between steps
STEPS_W, 8, width of the step-count field

Ports:
clock  in  1  25 MHz reference clock (same net as the PLL input)
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL LOCK output, asynchronous to clock
pll_rst  out  1  PLL RST, active high
phasesel  out  2  PLL PHASESEL[1:0], selects the output to shift
phasedir  out  1  PLL PHASEDIR
phasestep  out  1  PLL PHASESTEP, idle high, active-low pulse
req_valid  in  1  phase-shift request valid
req_sel  in  2  requested output select
req_dir  in  1  requested direction
req_count  in  STEPS_W  number of steps
req_ready  out  1  request accept
busy  out  1  phase-shift sequence in progress
sys_rst_n  out  1  system reset, deasserts synchronously to clock
relock_count  out  8  lock-loss events, saturating at 255

Behaviour:
- Reset is asynchronous and active-low: one clock, and reset_n low forces all state immediately.
- Reset values:
  - state=RESET_PLL, pll_rst=1, counters=0
  - phasestep=1, phasesel=0, phasedir=0
  - busy=0, sys_rst_n=0, relock_count=0
- Lock synchronizer: two flops; lock_s = synchronized pll_locked, 2-cycle latency. All decisions use lock_s only.
- req_ready is combinational: (state==RUN) && lock_s. A handshake is req_valid && req_ready.
- FSM states and transitions:
  - RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles; lock_s ignored; then WAIT_LOCK with the counter cleared.
  - WAIT_LOCK: pll_rst=0; the counter increments.
    - lock_s=1 -> STABLE, counter cleared.
    - Counter reaches LOCK_TIMEOUT-1 without lock -> RESET_PLL.
  - STABLE: the counter increments while lock_s=1.
    - lock_s=0 -> WAIT_LOCK; the timeout count restarts from 0.
    - Counter reaches LOCK_STABLE-1 -> RUN; sys_rst_n goes to 1 on the cycle RUN is entered.
  - RUN: idle, phasestep=1, busy=0. On handshake, latch req_sel, req_dir and req_count.
    - req_count==0: accepted, no pulses, stay in RUN.
    - Otherwise -> SETUP; phasesel/phasedir take the latched values on the next edge; busy=1.
  - SETUP: exactly 1 cycle with phasesel/phasedir stable and phasestep=1 (setup time); then STEP.
  - STEP: phasestep=0 for STEP_WIDTH cycles; then GAP with remaining decremented.
  - GAP: phasestep=1 for STEP_GAP cycles.
    - remaining==0 -> RUN (busy=0).
    - Otherwise -> STEP.
- phasesel and phasedir hold their last values in RUN; they are not cleared.
- Lock loss (lock_s=0) in RUN, SETUP, STEP or GAP takes effect on the next edge:
  - sys_rst_n=0, phasestep=1, busy=0
  - the in-flight request is discarded
  - relock_count increments, saturating at 255
  - state -> WAIT_LOCK
- Lock loss has priority over request acceptance; req_ready is already 0 in that cycle.
- reset_n asserted mid-sequence: phasestep returns to 1 and pll_rst to 1 immediately (asynchronous); the full reset sequence replays.
- Counter widths: sized to the largest of LOCK_TIMEOUT, LOCK_STABLE, RST_CYCLES, STEP_WIDTH and STEP_GAP; compares are against value-1. All parameters must be >=1.
- sys_rst_n and all PLL-facing outputs are registered; no combinational path from pll_locked to any output.

Test Plan:
Bench parameters: LOCK_STABLE=8, LOCK_TIMEOUT=32, RST_CYCLES=4, STEP_WIDTH=2, STEP_GAP=3.
- Release reset; pll_locked rises 10 cycles later and stays high -> pll_rst high for cycles 0-3; sys_rst_n rises exactly 2+8 cycles after the first lock_s sample; req_ready=1.
- pll_locked held low -> pll_rst pulses high for 4 cycles, repeating every 4+32 cycles; sys_rst_n stays 0.
- In RUN, request sel=2, dir=1, count=3 -> phasesel=2 and phasedir=1 one cycle before the first pulse; three phasestep low pulses of 2 cycles, each followed by a 3-cycle gap; busy high throughout; req_ready returns to 1 after the third gap.
- Request count=0 -> handshake completes; phasestep never toggles; busy stays 0; req_ready stays 1.
- pll_locked drops during the second STEP pulse -> phasestep=1 and sys_rst_n=0 within 3 cycles; relock_count=1; relock then yields sys_rst_n=1; the old request is not resumed.
- In STABLE, pll_locked glitches low for 1 cycle at stable count 5 -> state returns to WAIT_LOCK and the stable count restarts; sys_rst_n is delayed by a full 8-cycle window.
